fir_out_fifo: RTL and testbench
===============================

# fir_out_fifo

Output capture buffer that sits directly downstream of the floating-point FIR stage. It samples the 14-bit offset-binary filter result once per downsampled period, qualified by the FIR's valid flag. Samples are held in a small FIFO and presented on a ready/valid stream so a slower or bursty consumer (serializer, host readout) can drain them. Lost samples are counted, and the first sample of each valid run is tagged.

## Interface
Parameters:
- WIDTH, 14: sample width; matches the FIR output width.
- DEPTH, 16: FIFO entries; must be a power of 2 and at least 2.
- CNT_W, 16: width of the drop counter.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-low reset.
- in  in  WIDTH  FIR result, offset-binary.
- in_stb  in  1  one-cycle pulse per downsampled period; `in` is stable while it is high.
- in_valid  in  1  FIR data-valid level.
- out_data  out  WIDTH  head-of-FIFO sample.
- out_first  out  1  head sample is the first accepted sample of a valid run.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the head this cycle.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; a sample was dropped.
- drop_cnt  out  CNT_W  number of dropped samples, saturating.
- clr_ovf  in  1  clears overflow and drop_cnt.

## Operation
- Storage: DEPTH x (WIDTH+1) register array. Each entry holds {first, sample}.
- Pointers are log2(DEPTH)+1 bits with wrap bit. Definitions:
  - empty = pointers equal.
  - full = indices equal and wrap bits differ.
- Write request: wr = in_stb & in_valid. in_stb while in_valid=0 is ignored entirely; no drop is counted.
- Pop: pop = out_valid & out_ready.
- Accept rule: the write is accepted if !full, or if full & pop in the same cycle (simultaneous pop frees a slot).
- Drop rule: wr & full & !pop drops the sample.
  - overflow <= 1.
  - drop_cnt increments, saturating at 2^CNT_W-1.
- First tag:
  - first_pend is set by reset and on any cycle where in_valid=0.
  - On an accepted write, the entry's first bit = first_pend, and first_pend clears.
  - A dropped sample does not consume first_pend.
- level: +1 on accepted write, -1 on pop, unchanged when both occur.
- Output is first-word-fall-through:
  - out_valid = !empty.
  - out_data and out_first read combinationally from mem[rd_idx].
- When out_valid=0, out_data/out_first are don't-care; the bench must not check them.
- clr_ovf: overflow <= 0 and drop_cnt <= 0. If a drop occurs in the same cycle, the drop wins: overflow=1, drop_cnt=1.
- No reordering and no duplication. Data order is strictly FIFO.

## Timing
- Reset (rst=0 at an edge) results after that edge:
  - pointers, level, drop_cnt = 0.
  - out_valid = 0, overflow = 0, first_pend = 1.
  - FIFO contents discarded.
- Reset mid-operation behaves the same way. An in_stb coincident with rst=0 is discarded.
- Write latency: a sample accepted at edge k is visible on out_data (out_valid=1 if it was empty) immediately after edge k. This is one cycle from in_stb to out_valid.
- Pop latency: with out_ready=1 at edge k, the next entry (or out_valid=0) is visible after edge k.
- Simultaneous write and pop on an empty FIFO cannot occur, because pop requires out_valid=1.
- Pointer wrap at DEPTH is seamless. Occupancy is exact across the wrap.
- Throughput: one write and one pop per cycle. in_stb spacing (DSR clk cycles) is irrelevant to correctness.

## Test plan
- Reset and basic flow:
  - Stimulus: rst low for 2 cycles; then in_valid=1, 3 strobes (in=0x0001, 0x2000, 0x3FFF); out_ready=1.
  - Required: out_valid pulses once per sample; values appear in order; first bit = 1 only on 0x0001; level never exceeds 1.
- Fill and overflow:
  - Stimulus: out_ready=0; 18 strobes with DEPTH=16, in=0..17.
  - Required: level=16, overflow=1, drop_cnt=2. Draining yields 0..15, with out_first only on 0.
- Full with simultaneous pop:
  - Stimulus: FIFO full; a strobe coincident with out_ready=1.
  - Required: no drop; level stays 16; the new sample is last out.
- Valid gating and first tag:
  - Stimulus: strobes while in_valid=0 (ignored, drop_cnt unchanged). Then in_valid toggles 1→0→1 with 2 samples per run.
  - Required: the first sample of each run has out_first=1, all others 0.
- Clear versus drop race:
  - Stimulus: FIFO full, drop_cnt=5; clr_ovf coincident with a drop.
  - Required: drop_cnt=1 and overflow=1. A subsequent clr_ovf alone gives 0/0.
- Wrap-around and mid-stream reset:
  - Stimulus: 40 samples with random out_ready; compare against a scoreboard. Then assert rst=0 while level=7.
  - Required: output is in order with no loss while not full. After reset: level=0, out_valid=0, drop_cnt=0.

Source files
------------

// File: rtl/fir_out_fifo.sv
// Output capture FIFO behind the FIR stage: samples the filter result on each
// qualified strobe, tags the first sample of each valid run, counts drops.
module fir_out_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 16,   // power of 2, >= 2
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in,
  input  logic                     in_stb,
  input  logic                     in_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_first,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH:0]    r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [AW:0]       r_level;
  logic              r_overflow;
  logic              r_first_pend;
  logic [CNT_W-1:0]  r_drop_cnt;

  logic [AW-1:0]     w_wr_idx;
  logic [AW-1:0]     w_rd_idx;
  logic              w_empty;
  logic              w_full;
  logic              w_wr;
  logic              w_pop;
  logic              w_accept;
  logic              w_drop;
  logic [WIDTH:0]    w_head;

  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_rd_idx = r_rd_ptr[AW-1:0];
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (w_wr_idx == w_rd_idx) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // Handshake: the head is transferred on any edge where out_valid and
  // out_ready are both high; out_valid never depends on out_ready.
  assign w_wr     = in_stb & in_valid;
  assign w_pop    = ~w_empty & out_ready;
  // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
  assign w_accept = w_wr & (~w_full | w_pop);
  assign w_drop   = w_wr & w_full & ~w_pop;

  assign w_head    = r_mem[w_rd_idx];
  assign out_data  = w_head[WIDTH-1:0];
  assign out_first = w_head[WIDTH];
  assign out_valid = ~w_empty;
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

  // Storage is not reset; the pointers alone define what is live.
  always_ff @(posedge clk) begin
    if (rst && w_accept) begin
      r_mem[w_wr_idx] <= {r_first_pend, in};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_accept, w_pop})
        2'b10:   r_level <= r_level + PTR_ONE;
        2'b01:   r_level <= r_level - PTR_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // A dropped sample leaves first_pend armed for the next accepted one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_first_pend <= 1'b1;
    end else if (!in_valid) begin
      r_first_pend <= 1'b1;
    end else if (w_accept) begin
      r_first_pend <= 1'b0;
    end
  end

  // A drop coincident with a clear wins and counts as the first new drop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clr_ovf) begin
        r_drop_cnt <= CNT_ONE;
      end else if (r_drop_cnt != CNT_MAX) begin
        r_drop_cnt <= r_drop_cnt + CNT_ONE;
      end
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_fir_out_fifo.sv
// Bench for fir_out_fifo: vector table for the basic flow, directed corner
// sequences, and randomized traffic checked against a queue-based model.
module tb_fir_out_fifo;

  logic        clk;
  logic        rst;
  logic [13:0] din;
  logic        in_stb;
  logic        in_valid;
  logic [13:0] out_data;
  logic        out_first;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic        clr_ovf;

  int n_checks = 0;
  int n_errors = 0;

  fir_out_fifo #(.WIDTH(14), .DEPTH(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in(din), .in_stb(in_stb), .in_valid(in_valid),
    .out_data(out_data), .out_first(out_first), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .overflow(overflow),
    .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: a queue of {first, sample} plus status
  logic [14:0] m_q[$];
  bit          m_fp = 1'b1;
  bit          m_ovf = 1'b0;
  int          m_drop = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit full, pop, wr;
    if (!rst) begin
      m_q.delete();
      m_fp = 1'b1;
      m_ovf = 1'b0;
      m_drop = 0;
      return;
    end
    full = (m_q.size() == 16);
    pop  = (m_q.size() > 0) && out_ready;
    wr   = in_stb && in_valid;
    if (pop) void'(m_q.pop_front());
    if (wr && (!full || pop)) begin
      m_q.push_back({m_fp, din});
      m_fp = 1'b0;
    end
    if (!in_valid) m_fp = 1'b1;
    if (wr && full && !pop) begin
      m_ovf = 1'b1;
      if (clr_ovf) m_drop = 1;
      else if (m_drop < 65535) m_drop++;
    end else if (clr_ovf) begin
      m_ovf = 1'b0;
      m_drop = 0;
    end
  endtask

  task automatic check_model();
    check("mdl_level", level, m_q.size());
    check("mdl_out_valid", out_valid, m_q.size() != 0);
    if (m_q.size() > 0) begin
      check("mdl_out_data", out_data, m_q[0][13:0]);
      check("mdl_out_first", out_first, m_q[0][14]);
    end
    check("mdl_overflow", overflow, m_ovf);
    check("mdl_drop_cnt", drop_cnt, m_drop);
  endtask

  // driver tasks
  task automatic drive(input logic r, input logic [13:0] d, input logic s,
                       input logic v, input logic rdy, input logic c);
    rst = r; din = d; in_stb = s; in_valid = v; out_ready = rdy; clr_ovf = c;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic pop_expect(input string name, input logic [13:0] d, input logic f);
    check({name, "_valid"}, out_valid, 1'b1);
    check({name, "_data"}, out_data, d);
    check({name, "_first"}, out_first, f);
    drive(1'b1, 14'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
  endtask

  typedef struct {
    logic        rst;
    logic [13:0] din;
    logic        stb;
    logic        vld;
    logic        rdy;
    logic        clr;
    logic        e_valid;
    logic [13:0] e_data;
    logic        e_first;
    logic [4:0]  e_level;
    logic        e_ovf;
    logic [15:0] e_drop;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int strobes;
    drive(1'b0, 14'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset and basic flow
    vecs[0] = '{1'b0, 14'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 14'h0000, 1'b0, 5'd0, 1'b0, 16'd0};
    vecs[1] = '{1'b0, 14'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 14'h0000, 1'b0, 5'd0, 1'b0, 16'd0};
    vecs[2] = '{1'b1, 14'h0001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 14'h0001, 1'b1, 5'd1, 1'b0, 16'd0};
    vecs[3] = '{1'b1, 14'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 14'h0000, 1'b0, 5'd0, 1'b0, 16'd0};
    vecs[4] = '{1'b1, 14'h2000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 14'h2000, 1'b0, 5'd1, 1'b0, 16'd0};
    vecs[5] = '{1'b1, 14'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 14'h0000, 1'b0, 5'd0, 1'b0, 16'd0};
    vecs[6] = '{1'b1, 14'h3FFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 14'h3FFF, 1'b0, 5'd1, 1'b0, 16'd0};
    vecs[7] = '{1'b1, 14'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 14'h0000, 1'b0, 5'd0, 1'b0, 16'd0};
    vecs[8] = '{1'b1, 14'h1234, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 14'h0000, 1'b0, 5'd0, 1'b0, 16'd0};
    vecs[9] = '{1'b1, 14'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 14'h0000, 1'b0, 5'd0, 1'b0, 16'd0};
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].rst, vecs[i].din, vecs[i].stb, vecs[i].vld, vecs[i].rdy, vecs[i].clr);
      step();
      check("vec_out_valid", out_valid, vecs[i].e_valid);
      check("vec_level", level, vecs[i].e_level);
      check("vec_overflow", overflow, vecs[i].e_ovf);
      check("vec_drop_cnt", drop_cnt, vecs[i].e_drop);
      if (vecs[i].e_valid) begin
        check("vec_out_data", out_data, vecs[i].e_data);
        check("vec_out_first", out_first, vecs[i].e_first);
      end
    end

    // fill and overflow
    drive(1'b1, 14'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, 14'(i), 1'b1, 1'b1, 1'b0, 1'b0);
      step();
    end
    check("fill_level", level, 5'd16);
    check("fill_overflow", overflow, 1'b1);
    check("fill_drop_cnt", drop_cnt, 16'd2);
    for (int i = 0; i < 16; i++) pop_expect("fill_drain", 14'(i), i == 0);
    check("fill_empty", out_valid, 1'b0);
    drive(1'b1, 14'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    check("clr_drop_cnt", drop_cnt, 16'd0);

    // full with simultaneous pop
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 14'(100 + i), 1'b1, 1'b1, 1'b0, 1'b0);
      step();
    end
    check("fullpop_pre_level", level, 5'd16);
    drive(1'b1, 14'h1ABC, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    check("fullpop_level", level, 5'd16);
    check("fullpop_drop_cnt", drop_cnt, 16'd0);
    check("fullpop_overflow", overflow, 1'b0);
    for (int i = 0; i < 16; i++)
      pop_expect("fullpop_drain", (i < 15) ? 14'(101 + i) : 14'h1ABC, 1'b0);

    // valid gating and first tag
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 14'($urandom_range(0, 16383)), 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      check("gate_level", level, 5'd0);
      check("gate_drop_cnt", drop_cnt, 16'd0);
    end
    drive(1'b1, 14'd10, 1'b1, 1'b1, 1'b0, 1'b0); step();
    drive(1'b1, 14'd0,  1'b0, 1'b1, 1'b0, 1'b0); step();
    drive(1'b1, 14'd11, 1'b1, 1'b1, 1'b0, 1'b0); step();
    drive(1'b1, 14'd0,  1'b0, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 14'd12, 1'b1, 1'b1, 1'b0, 1'b0); step();
    drive(1'b1, 14'd13, 1'b1, 1'b1, 1'b0, 1'b0); step();
    pop_expect("run_a0", 14'd10, 1'b1);
    pop_expect("run_a1", 14'd11, 1'b0);
    pop_expect("run_b0", 14'd12, 1'b1);
    pop_expect("run_b1", 14'd13, 1'b0);

    // clear versus drop race
    for (int i = 0; i < 21; i++) begin
      drive(1'b1, 14'(200 + i), 1'b1, 1'b1, 1'b0, 1'b0);
      step();
    end
    check("race_pre_drop_cnt", drop_cnt, 16'd5);
    drive(1'b1, 14'h0777, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    check("race_drop_cnt", drop_cnt, 16'd1);
    check("race_overflow", overflow, 1'b1);
    drive(1'b1, 14'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    check("clr_only_drop_cnt", drop_cnt, 16'd0);
    check("clr_only_overflow", overflow, 1'b0);

    // randomized traffic with wrap-around
    strobes = 0;
    for (int c = 0; c < 600 && strobes < 40; c++) begin
      logic s;
      s = ($urandom_range(0, 1) == 1);
      if (s) strobes++;
      drive(1'b1, 14'($urandom_range(0, 16383)), s, ($urandom_range(0, 7) != 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
      step();
    end
    check("rand_strobes", strobes, 40);

    // mid-stream reset at level 7
    for (int c = 0; c < 64 && m_q.size() != 7; c++) begin
      if (m_q.size() < 7) drive(1'b1, 14'($urandom_range(0, 16383)), 1'b1, 1'b1, 1'b0, 1'b0);
      else                drive(1'b1, 14'h0, 1'b0, 1'b1, 1'b1, 1'b0);
      step();
    end
    check("pre_reset_level", level, 5'd7);
    drive(1'b0, 14'h2AAA, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check("reset_level", level, 5'd0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_drop_cnt", drop_cnt, 16'd0);
    check("reset_overflow", overflow, 1'b0);
    drive(1'b1, 14'h0155, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check("post_reset_data", out_data, 14'h0155);
    check("post_reset_first", out_first, 1'b1);
    check("post_reset_level", level, 5'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
